alu_uart_ctrl: RTL and testbench
================================

# alu_uart_ctrl

Frame controller between the UART receiver/transmitter and the ALU. It collects three bytes from the UART receive path: operand A, then operand B, then opcode. It presents them to the ALU as registered outputs, captures the ALU result one cycle later and hands it to the UART transmitter. It then waits for transmit completion before accepting the next frame.

## Interface
Parameters:
- NB_DATA, 8, width of UART bytes, operands and result
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte
- TIMEOUT_CYCLES, 50000000, maximum clock cycles allowed between bytes of one frame (≥2)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data
- i_rx_data  in  NB_DATA  received byte
- i_tx_done  in  1  one-cycle pulse: transmitter finished a byte
- i_alu_result  in  NB_DATA  combinational ALU result
- o_data_a  out  NB_DATA  registered operand A
- o_data_b  out  NB_DATA  registered operand B
- o_op  out  NB_OP  registered opcode
- o_tx_start  out  1  one-cycle transmit request
- o_tx_data  out  NB_DATA  byte to transmit, held until the next capture
- o_busy  out  1  high in any state except WAIT_A
- o_drop  out  1  one-cycle pulse: a byte arrived in EXEC or WAIT_TX and was discarded
- o_timeout  out  1  one-cycle pulse: a partial frame was aborted

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, WAIT_TX.
- Reset: state=WAIT_A, all data outputs 0, all pulses 0, timeout counter 0.
- WAIT_A: on i_rx_done, o_data_a←i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b←i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_op←i_rx_data[NB_OP-1:0], go to EXEC.
- EXEC: unconditionally o_tx_data←i_alu_result, o_tx_start←1, go to WAIT_TX.
- WAIT_TX: on i_tx_done, go to WAIT_A. o_tx_start is low here.
- Bytes arriving in EXEC or WAIT_TX are not stored; each one pulses o_drop. The outputs o_data_a, o_data_b and o_op are unchanged.
- The outputs o_data_a, o_data_b and o_op keep their values until overwritten by the next frame. They are never cleared except by reset.
- Timeout counter: width $clog2(TIMEOUT_CYCLES). Cleared on every accepted byte and in WAIT_A, EXEC and WAIT_TX. Increments each cycle in WAIT_B and WAIT_OP.
- When the counter reaches TIMEOUT_CYCLES-1 with no i_rx_done in that cycle: go to WAIT_A, pulse o_timeout, clear the counter. Operand registers are not cleared.
- If i_rx_done and expiry coincide, the byte is accepted and no timeout occurs.
- An i_tx_done outside WAIT_TX is ignored.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Opcode byte i_rx_done sampled at edge k: o_op is valid after edge k, and the state is EXEC during cycle k→k+1.
- i_alu_result is sampled at edge k+1. o_tx_data is valid and o_tx_start is high during cycle k+1→k+2, exactly one cycle.
- Latency from opcode i_rx_done to o_tx_start is 2 edges.
- The ALU has one full cycle from o_op/operand update to result capture.
- o_busy rises the edge after operand A is accepted. It falls the edge after i_tx_done is sampled in WAIT_TX.
- A new frame can be accepted in the cycle after the return to WAIT_A.
- Reset asserted mid-frame or mid-transmit forces WAIT_A immediately, without waiting for a clock edge. No o_tx_start is issued afterwards.

## Configuration
- Macro ALU_CTRL_TIMEOUT_EN.
- Defined: the inter-byte timeout described above is built, and o_timeout can pulse.
- Undefined: no counter is built, WAIT_B and WAIT_OP wait indefinitely, and o_timeout is tied to 0.

## Test plan
- Frame 0x05, 0x03, 0x20 with the ALU model result A+B → o_data_a=0x05, o_data_b=0x03, o_op=0x20. o_tx_start pulses once, 2 edges after the third i_rx_done, with o_tx_data=0x08. After i_tx_done, o_busy=0.
- Byte injected during WAIT_TX → one o_drop pulse; operands unchanged. After i_tx_done, the next frame 0xFF, 0x01, 0x20 yields o_tx_data=0x00 (wrap).
- With TIMEOUT_CYCLES=16 and the macro defined: send 0x11, then idle for 16 cycles → o_timeout pulses once and the state returns to WAIT_A. A following full frame is processed normally.
- Same setup, with the second byte arriving exactly on the expiry cycle → accepted, no o_timeout.
- Same idle with the macro undefined → o_timeout stays 0 and the block still accepts B after 100 cycles.
- Reset pulse asserted one cycle after the opcode byte → no o_tx_start, all outputs 0, o_busy=0.

Source files
------------

// File: rtl/alu_uart_ctrl.sv
// Frame controller between the UART and the ALU.
// Collects operand A, operand B and opcode bytes, presents them to the ALU as registered
// outputs, captures the ALU result one cycle later and hands it to the UART transmitter,
// then waits for transmit completion before accepting the next frame.
// Optional feature: define ALU_CTRL_TIMEOUT_EN to build the inter-byte timeout that
// aborts a partial frame; without it WAIT_B/WAIT_OP wait indefinitely and o_timeout is 0.
module alu_uart_ctrl #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StWaitTx
  } state_e;

  state_e state_q;

  // Only the low NB_OP bits of the opcode byte are architecturally meaningful.
  logic unused_rx_bits;
  assign unused_rx_bits = ^i_rx_data;

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] timeout_cnt_q;
  logic            cnt_active;
  logic            cnt_expired;

  assign cnt_active  = (state_q == StWaitB) || (state_q == StWaitOp);
  assign cnt_expired = (timeout_cnt_q == CntLast);

  // Inter-byte counter: runs only while a partial frame is pending, cleared otherwise.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      timeout_cnt_q <= '0;
    end else if (cnt_active && !i_rx_done && !cnt_expired) begin
      timeout_cnt_q <= timeout_cnt_q + CntW'(1);
    end else begin
      timeout_cnt_q <= '0;
    end
  end
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign o_timeout = 1'b0;
`endif

  // Frame sequencing FSM with all outputs registered.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= StWaitA;
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op       <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_drop     <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
      o_timeout  <= 1'b0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_drop     <= 1'b0;
`ifdef ALU_CTRL_TIMEOUT_EN
      o_timeout  <= 1'b0;
`endif
      case (state_q)
        StWaitA: begin
          if (i_rx_done) begin
            o_data_a <= i_rx_data;
            o_busy   <= 1'b1;
            state_q  <= StWaitB;
          end
        end
        StWaitB: begin
          if (i_rx_done) begin
            o_data_b <= i_rx_data;
            state_q  <= StWaitOp;
          end
`ifdef ALU_CTRL_TIMEOUT_EN
          else if (cnt_expired) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state_q   <= StWaitA;
          end
`endif
        end
        StWaitOp: begin
          if (i_rx_done) begin
            o_op    <= i_rx_data[NB_OP-1:0];
            state_q <= StExec;
          end
`ifdef ALU_CTRL_TIMEOUT_EN
          else if (cnt_expired) begin
            o_timeout <= 1'b1;
            o_busy    <= 1'b0;
            state_q   <= StWaitA;
          end
`endif
        end
        StExec: begin
          // ALU has had a full cycle since the opcode/operands settled.
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_drop     <= i_rx_done;
          state_q    <= StWaitTx;
        end
        StWaitTx: begin
          o_drop <= i_rx_done;
          if (i_tx_done) begin
            o_busy  <= 1'b0;
            state_q <= StWaitA;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          state_q <= StWaitA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed frames, randomized frames against a
// transaction-level model, drop/timeout behaviour and asynchronous reset mid-frame.
module tb_alu_uart_ctrl;

  localparam int unsigned NbData = 8;
  localparam int unsigned NbOp   = 6;
  localparam int unsigned ToCyc  = 16;

  logic              clk;
  logic              rst_n;
  logic              rx_done;
  logic [NbData-1:0] rx_data;
  logic              tx_done;
  logic [NbData-1:0] alu_result;
  logic [NbData-1:0] data_a;
  logic [NbData-1:0] data_b;
  logic [NbOp-1:0]   op;
  logic              tx_start;
  logic [NbData-1:0] tx_data;
  logic              busy;
  logic              drop;
  logic              timeout;

  int n_checks;
  int n_fail;

  alu_uart_ctrl #(
    .NB_DATA       (NbData),
    .NB_OP         (NbOp),
    .TIMEOUT_CYCLES(ToCyc)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx_done   (rx_done),
    .i_rx_data   (rx_data),
    .i_tx_done   (tx_done),
    .i_alu_result(alu_result),
    .o_data_a    (data_a),
    .o_data_b    (data_b),
    .o_op        (op),
    .o_tx_start  (tx_start),
    .o_tx_data   (tx_data),
    .o_busy      (busy),
    .o_drop      (drop),
    .o_timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] o);
    case (o)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_model(data_a, data_b, op);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  // Drives a full frame with no gaps, reports whether tx_start appeared exactly two
  // edges after the opcode byte, and what tx_data held then; finishes with tx_done.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ob,
                           output logic lat_ok, output logic [7:0] txd);
    send_byte(a);
    send_byte(b);
    send_byte(ob);
    lat_ok = (tx_start === 1'b0);
    step();
    lat_ok = lat_ok && (tx_start === 1'b1);
    txd = tx_data;
    step();
    lat_ok = lat_ok && (tx_start === 1'b0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    tx_done = 1'b0;
    step();
    step();
    n_checks++;
    if ({data_a, data_b, op, tx_start, tx_data, busy, drop, timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h st=%b txd=%h busy=%b drop=%b to=%b, want all 0",
               data_a, data_b, op, tx_start, tx_data, busy, drop, timeout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // A tx_done while idle must be ignored.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    step();
    n_checks++;
    if ({busy, tx_start} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b tx_start=%b, want 0 0", busy, tx_start);
    end
  endtask

  task automatic test_basic_frame();
    send_byte(8'h05);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: got %b want 1", busy);
    end
    send_byte(8'h03);
    send_byte(8'h20);
    n_checks++;
    if ({data_a, data_b, op} !== {8'h05, 8'h03, 6'h20}) begin
      n_fail++;
      $display("FAIL basic_operands: got %h %h %h want 05 03 20", data_a, data_b, op);
    end
    n_checks++;
    if (tx_start !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_start: got tx_start=%b one edge after opcode, want 0", tx_start);
    end
    step();
    n_checks++;
    if ({tx_start, tx_data} !== {1'b1, 8'h08}) begin
      n_fail++;
      $display("FAIL basic_tx: got start=%b data=%h want 1 08", tx_start, tx_data);
    end
    step();
    n_checks++;
    if ({tx_start, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_start_width: got start=%b busy=%b want 0 1", tx_start, busy);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    n_checks++;
    if ({busy, tx_data} !== {1'b0, 8'h08}) begin
      n_fail++;
      $display("FAIL basic_done: got busy=%b tx_data=%h want 0 08", busy, tx_data);
    end
  endtask

  task automatic test_drop_and_wrap();
    logic       ok;
    logic [7:0] txd;
    send_byte(8'h44);
    send_byte(8'h11);
    send_byte(8'h26);
    step();
    step();
    send_byte(8'hAA);
    n_checks++;
    if ({drop, data_a, data_b, op} !== {1'b1, 8'h44, 8'h11, 6'h26}) begin
      n_fail++;
      $display("FAIL drop_pulse: got drop=%b a=%h b=%h op=%h want 1 44 11 26",
               drop, data_a, data_b, op);
    end
    step();
    n_checks++;
    if ({drop, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_width: got drop=%b busy=%b want 0 1", drop, busy);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    run_frame(8'hFF, 8'h01, 8'h20, ok, txd);
    n_checks++;
    if ({ok, txd, busy} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL wrap_frame: got lat_ok=%b tx_data=%h busy=%b want 1 00 0", ok, txd, busy);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] a, b, ob, junk;
    logic [5:0] ops [6];
    logic       inj_exec, inj_tx;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    for (int i = 0; i < 12; i++) begin
      a        = 8'($urandom);
      b        = 8'($urandom);
      ob       = {2'($urandom), ops[$urandom_range(0, 5)]};
      junk     = 8'($urandom);
      inj_exec = 1'($urandom);
      inj_tx   = 1'($urandom);
      send_byte(a);
      repeat ($urandom_range(0, 3)) step();
      send_byte(b);
      repeat ($urandom_range(0, 3)) step();
      send_byte(ob);
      n_checks++;
      if ({data_a, data_b, op} !== {a, b, ob[5:0]}) begin
        n_fail++;
        $display("FAIL rand_operands[%0d]: got %h %h %h want %h %h %h",
                 i, data_a, data_b, op, a, b, ob[5:0]);
      end
      if (inj_exec) begin
        rx_data = junk;
        rx_done = 1'b1;
      end
      step();
      rx_done = 1'b0;
      n_checks++;
      if ({tx_start, tx_data, drop} !== {1'b1, alu_model(a, b, ob[5:0]), inj_exec}) begin
        n_fail++;
        $display("FAIL rand_tx[%0d]: got start=%b data=%h drop=%b want 1 %h %b",
                 i, tx_start, tx_data, drop, alu_model(a, b, ob[5:0]), inj_exec);
      end
      step();
      repeat ($urandom_range(0, 3)) step();
      if (inj_tx) begin
        send_byte(junk);
        n_checks++;
        if ({drop, data_a, data_b, op, tx_start} !== {1'b1, a, b, ob[5:0], 1'b0}) begin
          n_fail++;
          $display("FAIL rand_drop[%0d]: got drop=%b a=%h b=%h op=%h st=%b", i, drop, data_a,
                   data_b, op, tx_start);
        end
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      n_checks++;
      if ({busy, tx_data} !== {1'b0, alu_model(a, b, ob[5:0])}) begin
        n_fail++;
        $display("FAIL rand_done[%0d]: got busy=%b tx_data=%h", i, busy, tx_data);
      end
    end
  endtask

`ifdef ALU_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic       early;
    logic       ok;
    logic [7:0] txd;
    early = 1'b0;
    send_byte(8'h11);
    for (int i = 1; i < ToCyc; i++) begin
      step();
      if (timeout !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if ({early, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_early: got early=%b busy=%b want 0 1", early, busy);
    end
    step();
    n_checks++;
    if ({timeout, busy, data_a} !== {1'b1, 1'b0, 8'h11}) begin
      n_fail++;
      $display("FAIL timeout_pulse: got to=%b busy=%b a=%h want 1 0 11", timeout, busy, data_a);
    end
    step();
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_width: got %b want 0", timeout);
    end
    run_frame(8'h02, 8'h03, 8'h20, ok, txd);
    n_checks++;
    if ({ok, txd, data_a} !== {1'b1, 8'h05, 8'h02}) begin
      n_fail++;
      $display("FAIL timeout_recover: got lat_ok=%b tx=%h a=%h want 1 05 02", ok, txd, data_a);
    end
  endtask

  task automatic test_timeout_boundary();
    logic seen;
    seen = 1'b0;
    send_byte(8'h21);
    for (int i = 1; i < ToCyc; i++) begin
      step();
      if (timeout !== 1'b0) seen = 1'b1;
    end
    // This byte is sampled on the expiry edge.
    send_byte(8'h07);
    n_checks++;
    if ({seen, timeout, busy, data_b} !== {1'b0, 1'b0, 1'b1, 8'h07}) begin
      n_fail++;
      $display("FAIL boundary_accept: got seen=%b to=%b busy=%b b=%h want 0 0 1 07",
               seen, timeout, busy, data_b);
    end
    send_byte(8'h22);
    step();
    n_checks++;
    if ({tx_start, tx_data} !== {1'b1, 8'h1A}) begin
      n_fail++;
      $display("FAIL boundary_tx: got start=%b data=%h want 1 1a", tx_start, tx_data);
    end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    logic seen;
    seen = 1'b0;
    send_byte(8'h11);
    for (int i = 0; i < 100; i++) begin
      step();
      if (timeout !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if ({seen, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL no_timeout_idle: got seen=%b busy=%b want 0 1", seen, busy);
    end
    send_byte(8'h22);
    n_checks++;
    if ({data_a, data_b} !== {8'h11, 8'h22}) begin
      n_fail++;
      $display("FAIL no_timeout_accept: got a=%h b=%h want 11 22", data_a, data_b);
    end
    send_byte(8'h20);
    step();
    n_checks++;
    if ({tx_start, tx_data} !== {1'b1, 8'h33}) begin
      n_fail++;
      $display("FAIL no_timeout_tx: got start=%b data=%h want 1 33", tx_start, tx_data);
    end
    step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic       started;
    logic       ok;
    logic [7:0] txd;
    started = 1'b0;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({data_a, data_b, op, tx_start, tx_data, busy, drop, timeout} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got a=%h b=%h op=%h st=%b txd=%h busy=%b, want all 0",
               data_a, data_b, op, tx_start, tx_data, busy);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tx_start !== 1'b0) started = 1'b1;
    end
    n_checks++;
    if ({started, busy, data_a, op} !== '0) begin
      n_fail++;
      $display("FAIL reset_no_start: got started=%b busy=%b a=%h op=%h want all 0",
               started, busy, data_a, op);
    end
    run_frame(8'h0F, 8'hF0, 8'h25, ok, txd);
    n_checks++;
    if ({ok, txd} !== {1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL reset_recover: got lat_ok=%b tx=%h want 1 ff", ok, txd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_frame();
    test_drop_and_wrap();
    test_random_frames();
`ifdef ALU_CTRL_TIMEOUT_EN
    test_timeout();
    test_timeout_boundary();
`else
    test_no_timeout();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
